// File: rtl/axi_bridge_if.sv
// rtl/axi_bridge_if.sv - cache-side request/return and AXI master signal bundle for axi_bridge
interface axi_bridge_if;
   // icache read request / return
   logic         i_rd_req;
   logic [2:0]   i_rd_type;
   logic [31:0]  i_rd_addr;
   logic         i_rd_rdy;
   logic         i_ret_valid;
   logic         i_ret_last;
   logic [31:0]  i_ret_data;
   // dcache read request / return
   logic         d_rd_req;
   logic [2:0]   d_rd_type;
   logic [31:0]  d_rd_addr;
   logic         d_rd_rdy;
   logic         d_ret_valid;
   logic         d_ret_last;
   logic [31:0]  d_ret_data;
   // dcache write request
   logic         d_wr_req;
   logic [2:0]   d_wr_type;
   logic [31:0]  d_wr_addr;
   logic [3:0]   d_wr_wstrb;
   logic [127:0] d_wr_data;
   logic         d_wr_rdy;
   // AXI AR
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic [1:0]   arlock;
   logic [3:0]   arcache;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   // AXI R
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   // AXI AW
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic [1:0]   awlock;
   logic [3:0]   awcache;
   logic [2:0]   awprot;
   logic         awvalid;
   logic         awready;
   // AXI W
   logic [3:0]   wid;
   logic [31:0]  wdata;
   logic [3:0]   wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   // AXI B
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   // The bridge: takes cache requests, masters the AXI bus
   modport master (
      input  i_rd_req, i_rd_type, i_rd_addr,
      output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
      input  d_rd_req, d_rd_type, d_rd_addr,
      output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
      input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
      output d_wr_rdy,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   // The surroundings: caches plus the AXI slave
   modport slave (
      output i_rd_req, i_rd_type, i_rd_addr,
      input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
      output d_rd_req, d_rd_type, d_rd_addr,
      input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
      output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
      input  d_wr_rdy,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_bridge.sv
// rtl/axi_bridge.sv - icache/dcache to AXI master bridge with one read and one write in flight
module axi_bridge #(
   parameter int LINE_WORDS = 4
) (
   input  logic         clk,
   input  logic         reset,
   axi_bridge_if.master bus
);

   localparam logic [2:0] T_BYTE    = 3'b000;
   localparam logic [2:0] T_HALF    = 3'b001;
   localparam logic [2:0] T_LINE    = 3'b100;
   localparam logic [7:0] LINE_LEN  = 8'(LINE_WORDS - 1);
   localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} w_state_t;

   function automatic logic [2:0] size_of(input logic [2:0] t);
      case (t)
         T_BYTE:  size_of = 3'd0;
         T_HALF:  size_of = 3'd1;
         default: size_of = 3'd2;
      endcase
   endfunction

   function automatic logic [7:0] len_of(input logic [2:0] t);
      len_of = (t == T_LINE) ? LINE_LEN : 8'd0;
   endfunction

   r_state_t      r_state_q, r_state_d;
   logic [31:0]   rd_addr_q, rd_addr_d;
   logic [2:0]    rd_type_q, rd_type_d;
   logic          rd_owner_q, rd_owner_d;   // 1 = dcache, 0 = icache

   w_state_t      w_state_q, w_state_d;
   logic [31:0]   wr_addr_q, wr_addr_d;
   logic [2:0]    wr_type_q, wr_type_d;
   logic [3:0]    wr_strb_q, wr_strb_d;
   logic [127:0]  wr_data_q, wr_data_d;
   logic [1:0]    beat_q, beat_d;

   logic          w_busy, d_hazard, i_hazard;
   logic          d_rd_rdy_c, i_rd_rdy_c;
   logic [31:0]   line_word;
   logic          wlast_c;
   logic          unused_resp;

   // A read may not overtake a pending write to the same 16-byte line
   assign w_busy     = (w_state_q != W_IDLE);
   assign d_hazard   = w_busy && (bus.d_rd_addr[31:4] == wr_addr_q[31:4]);
   assign i_hazard   = w_busy && (bus.i_rd_addr[31:4] == wr_addr_q[31:4]);
   assign d_rd_rdy_c = (r_state_q == R_IDLE) && !d_hazard && !bus.d_wr_req;
   assign i_rd_rdy_c = (r_state_q == R_IDLE) && !bus.d_rd_req && !i_hazard;

   assign bus.d_rd_rdy = d_rd_rdy_c;
   assign bus.i_rd_rdy = i_rd_rdy_c;
   assign bus.d_wr_rdy = (w_state_q == W_IDLE);

   // Read channel drives
   assign bus.arid    = {3'b000, rd_owner_q};
   assign bus.araddr  = rd_addr_q;
   assign bus.arlen   = len_of(rd_type_q);
   assign bus.arsize  = size_of(rd_type_q);
   assign bus.arburst = 2'b01;
   assign bus.arlock  = 2'b00;
   assign bus.arcache = 4'h0;
   assign bus.arprot  = 3'h0;
   assign bus.arvalid = (r_state_q == R_AR);
   assign bus.rready  = (r_state_q == R_DATA);

   // R beats go straight through to whichever cache owns the read
   assign bus.i_ret_valid = bus.rvalid && (r_state_q == R_DATA) && !rd_owner_q;
   assign bus.d_ret_valid = bus.rvalid && (r_state_q == R_DATA) && rd_owner_q;
   assign bus.i_ret_data  = bus.rdata;
   assign bus.d_ret_data  = bus.rdata;
   assign bus.i_ret_last  = bus.rlast;
   assign bus.d_ret_last  = bus.rlast;

   // Write channel drives
   assign bus.awid    = 4'd1;
   assign bus.awaddr  = wr_addr_q;
   assign bus.awlen   = len_of(wr_type_q);
   assign bus.awsize  = size_of(wr_type_q);
   assign bus.awburst = 2'b01;
   assign bus.awlock  = 2'b00;
   assign bus.awcache = 4'h0;
   assign bus.awprot  = 3'h0;
   assign bus.awvalid = (w_state_q == W_AW);
   assign bus.wid     = 4'd1;
   assign bus.wvalid  = (w_state_q == W_DATA);
   assign bus.wdata   = line_word;
   assign bus.wstrb   = (wr_type_q == T_LINE) ? 4'hF : wr_strb_q;
   assign bus.wlast   = wlast_c;
   assign bus.bready  = (w_state_q == W_B);

   // Response ids and codes carry no information this bridge acts on
   assign unused_resp = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

   // Pick the current W beat: lowest word first for lines, word 0 otherwise
   always_comb begin
      line_word = wr_data_q[31:0];
      if (wr_type_q == T_LINE) begin
         case (beat_q)
            2'd0:    line_word = wr_data_q[31:0];
            2'd1:    line_word = wr_data_q[63:32];
            2'd2:    line_word = wr_data_q[95:64];
            default: line_word = wr_data_q[127:96];
         endcase
      end
      wlast_c = (wr_type_q == T_LINE) ? (beat_q == LAST_BEAT) : 1'b1;
   end

   // Read FSM next state: grant dcache first, then AR, then collect R beats
   always_comb begin
      r_state_d  = r_state_q;
      rd_addr_d  = rd_addr_q;
      rd_type_d  = rd_type_q;
      rd_owner_d = rd_owner_q;
      case (r_state_q)
         R_IDLE: begin
            if (bus.d_rd_req && d_rd_rdy_c) begin
               rd_addr_d  = bus.d_rd_addr;
               rd_type_d  = bus.d_rd_type;
               rd_owner_d = 1'b1;
               r_state_d  = R_AR;
            end else if (bus.i_rd_req && i_rd_rdy_c) begin
               rd_addr_d  = bus.i_rd_addr;
               rd_type_d  = bus.i_rd_type;
               rd_owner_d = 1'b0;
               r_state_d  = R_AR;
            end
         end
         R_AR:   if (bus.arready) r_state_d = R_DATA;
         R_DATA: if (bus.rvalid && bus.rlast) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM state and latched request
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q  <= R_IDLE;
         rd_addr_q  <= '0;
         rd_type_q  <= '0;
         rd_owner_q <= 1'b0;
      end else begin
         r_state_q  <= r_state_d;
         rd_addr_q  <= rd_addr_d;
         rd_type_q  <= rd_type_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Write FSM next state: latch payload, AW, stream W beats, wait for B
   always_comb begin
      w_state_d = w_state_q;
      wr_addr_d = wr_addr_q;
      wr_type_d = wr_type_q;
      wr_strb_d = wr_strb_q;
      wr_data_d = wr_data_q;
      beat_d    = beat_q;
      case (w_state_q)
         W_IDLE: begin
            if (bus.d_wr_req) begin
               wr_addr_d = bus.d_wr_addr;
               wr_type_d = bus.d_wr_type;
               wr_strb_d = bus.d_wr_wstrb;
               wr_data_d = bus.d_wr_data;
               beat_d    = 2'd0;
               w_state_d = W_AW;
            end
         end
         W_AW: if (bus.awready) w_state_d = W_DATA;
         W_DATA: begin
            if (bus.wready) begin
               beat_d = beat_q + 2'd1;
               if (wlast_c) begin
                  beat_d    = 2'd0;
                  w_state_d = W_B;
               end
            end
         end
         W_B: if (bus.bvalid) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write FSM state, latched payload and beat counter
   always_ff @(posedge clk) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         wr_addr_q <= '0;
         wr_type_q <= '0;
         wr_strb_q <= '0;
         wr_data_q <= '0;
         beat_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         wr_addr_q <= wr_addr_d;
         wr_type_q <= wr_type_d;
         wr_strb_q <= wr_strb_d;
         wr_data_q <= wr_data_d;
         beat_q    <= beat_d;
      end
   end

endmodule

// File: tb/tb_axi_bridge.sv
// tb/tb_axi_bridge.sv - scoreboard bench for axi_bridge
module tb_axi_bridge;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   logic [32:0] i_q[$];
   logic [32:0] d_q[$];
   logic [36:0] w_q[$];

   axi_bridge_if ifc();

   axi_bridge #(.LINE_WORDS(4)) dut (.clk(clk), .reset(reset), .bus(ifc));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pop the scoreboard whenever the DUT hands out a return beat or a W beat
   always @(negedge clk) begin
      logic [32:0] e;
      logic [36:0] w;
      if (ifc.i_ret_valid) begin
         if (i_q.size() == 0) check("i_ret_spurious", 1'b1, 1'b0);
         else begin
            e = i_q.pop_front();
            check("i_ret_data", ifc.i_ret_data, e[31:0]);
            check("i_ret_last", ifc.i_ret_last, e[32]);
         end
      end
      if (ifc.d_ret_valid) begin
         if (d_q.size() == 0) check("d_ret_spurious", 1'b1, 1'b0);
         else begin
            e = d_q.pop_front();
            check("d_ret_data", ifc.d_ret_data, e[31:0]);
            check("d_ret_last", ifc.d_ret_last, e[32]);
         end
      end
      if (ifc.wvalid && ifc.wready) begin
         if (w_q.size() == 0) check("w_spurious", 1'b1, 1'b0);
         else begin
            w = w_q.pop_front();
            check("wdata", ifc.wdata, w[31:0]);
            check("wstrb", ifc.wstrb, w[35:32]);
            check("wlast", ifc.wlast, w[36]);
         end
      end
   end

   task automatic rd_req(input bit dside, input logic [2:0] typ, input logic [31:0] addr);
      int t = 0;
      if (dside) begin
         ifc.d_rd_req = 1'b1; ifc.d_rd_type = typ; ifc.d_rd_addr = addr;
      end else begin
         ifc.i_rd_req = 1'b1; ifc.i_rd_type = typ; ifc.i_rd_addr = addr;
      end
      @(negedge clk);
      while (!(dside ? ifc.d_rd_rdy : ifc.i_rd_rdy) && t < 50) begin @(negedge clk); t++; end
      check("rd_grant", dside ? ifc.d_rd_rdy : ifc.i_rd_rdy, 1'b1);
      @(posedge clk); #1;
      ifc.d_rd_req = 1'b0;
      ifc.i_rd_req = 1'b0;
   endtask

   task automatic wr_req(input logic [2:0] typ, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [127:0] data);
      int t = 0;
      ifc.d_wr_req = 1'b1; ifc.d_wr_type = typ; ifc.d_wr_addr = addr;
      ifc.d_wr_wstrb = strb; ifc.d_wr_data = data;
      @(negedge clk);
      while (!ifc.d_wr_rdy && t < 50) begin @(negedge clk); t++; end
      check("wr_grant", ifc.d_wr_rdy, 1'b1);
      @(posedge clk); #1;
      ifc.d_wr_req = 1'b0;
   endtask

   task automatic ar_accept(input int delay, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [31:0] addr);
      int t = 0;
      while (!ifc.arvalid && t < 50) begin @(posedge clk); #1; t++; end
      check("arvalid", ifc.arvalid, 1'b1);
      check("arid", ifc.arid, id);
      check("arlen", ifc.arlen, len);
      check("arsize", ifc.arsize, size);
      check("araddr", ifc.araddr, addr);
      check("arburst", ifc.arburst, 2'b01);
      repeat (delay) begin
         @(posedge clk); #1;
         check("ar_hold_valid", ifc.arvalid, 1'b1);
         check("ar_hold_addr", ifc.araddr, addr);
      end
      ifc.arready = 1'b1;
      @(posedge clk); #1;
      ifc.arready = 1'b0;
   endtask

   task automatic r_send(input int n, input logic [31:0] base, input bit dside, input bit final_beat);
      int t = 0;
      while (!ifc.rready && t < 50) begin @(posedge clk); #1; t++; end
      check("rready", ifc.rready, 1'b1);
      for (int k = 0; k < n; k++) begin
         logic        l;
         logic [31:0] dat;
         l   = final_beat && (k == n - 1);
         dat = base + 32'(k);
         ifc.rvalid = 1'b1; ifc.rdata = dat; ifc.rlast = l;
         if (dside) d_q.push_back({l, dat}); else i_q.push_back({l, dat});
         @(posedge clk); #1;
      end
      ifc.rvalid = 1'b0;
      ifc.rlast  = 1'b0;
   endtask

   task automatic aw_accept(input logic [7:0] len, input logic [2:0] size, input logic [31:0] addr);
      int t = 0;
      while (!ifc.awvalid && t < 50) begin @(posedge clk); #1; t++; end
      check("awvalid", ifc.awvalid, 1'b1);
      check("awid", ifc.awid, 4'd1);
      check("awlen", ifc.awlen, len);
      check("awsize", ifc.awsize, size);
      check("awaddr", ifc.awaddr, addr);
      check("awburst", ifc.awburst, 2'b01);
      ifc.awready = 1'b1;
      @(posedge clk); #1;
      ifc.awready = 1'b0;
   endtask

   task automatic w_accept(input int n);
      int t = 0;
      while (!ifc.wvalid && t < 50) begin @(posedge clk); #1; t++; end
      check("wvalid", ifc.wvalid, 1'b1);
      check("wid", ifc.wid, 4'd1);
      ifc.wready = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
      ifc.wready = 1'b0;
   endtask

   task automatic b_send();
      int t = 0;
      while (!ifc.bready && t < 50) begin @(posedge clk); #1; t++; end
      check("bready", ifc.bready, 1'b1);
      ifc.bvalid = 1'b1;
      @(posedge clk); #1;
      ifc.bvalid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ifc.i_rd_req = 0; ifc.i_rd_type = 0; ifc.i_rd_addr = 0;
      ifc.d_rd_req = 0; ifc.d_rd_type = 0; ifc.d_rd_addr = 0;
      ifc.d_wr_req = 0; ifc.d_wr_type = 0; ifc.d_wr_addr = 0; ifc.d_wr_wstrb = 0; ifc.d_wr_data = 0;
      ifc.arready = 0; ifc.rid = 0; ifc.rdata = 0; ifc.rresp = 0; ifc.rlast = 0; ifc.rvalid = 0;
      ifc.awready = 0; ifc.wready = 0; ifc.bid = 0; ifc.bresp = 0; ifc.bvalid = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_i_rd_rdy", ifc.i_rd_rdy, 1'b1);
      check("rst_d_rd_rdy", ifc.d_rd_rdy, 1'b1);
      check("rst_d_wr_rdy", ifc.d_wr_rdy, 1'b1);
      check("rst_valids", {ifc.arvalid, ifc.awvalid, ifc.wvalid, ifc.rready, ifc.bready}, 5'b0);
      @(posedge clk); #1;

      // Icache line read, arready one cycle late
      rd_req(1'b0, 3'b100, 32'h1C00_0040);
      ar_accept(1, 4'd0, 8'd3, 3'd2, 32'h1C00_0040);
      r_send(4, 32'hA000_0000, 1'b0, 1'b1);
      @(negedge clk);
      check("rd_done_rready", ifc.rready, 1'b0);
      @(posedge clk); #1;

      // Simultaneous requests: dcache wins, icache waits for the dcache rlast
      ifc.i_rd_req = 1; ifc.i_rd_type = 3'b010; ifc.i_rd_addr = 32'h0000_2000;
      ifc.d_rd_req = 1; ifc.d_rd_type = 3'b100; ifc.d_rd_addr = 32'h0000_3000;
      @(negedge clk);
      check("prio_d_rdy", ifc.d_rd_rdy, 1'b1);
      check("prio_i_rdy", ifc.i_rd_rdy, 1'b0);
      @(posedge clk); #1;
      ifc.d_rd_req = 0;
      ar_accept(0, 4'd1, 8'd3, 3'd2, 32'h0000_3000);
      r_send(3, 32'hB000_0000, 1'b1, 1'b0);
      @(negedge clk);
      check("prio_i_blocked", ifc.i_rd_rdy, 1'b0);
      @(posedge clk); #1;
      r_send(1, 32'hB000_0003, 1'b1, 1'b1);
      @(negedge clk);
      check("prio_i_after", ifc.i_rd_rdy, 1'b1);
      @(posedge clk); #1;
      ifc.i_rd_req = 0;
      ar_accept(0, 4'd0, 8'd0, 3'd2, 32'h0000_2000);
      r_send(1, 32'hC000_0000, 1'b0, 1'b1);

      // Dcache line write, lowest word first
      wr_req(3'b100, 32'h0000_0100, 4'h3, 128'h00004444_00003333_00002222_00001111);
      aw_accept(8'd3, 3'd2, 32'h0000_0100);
      for (int k = 0; k < 4; k++) w_q.push_back({(k == 3), 4'hF, 32'h1111 * 32'(k + 1)});
      w_accept(4);
      @(negedge clk);
      check("wr_busy_in_b", ifc.d_wr_rdy, 1'b0);
      @(posedge clk); #1;
      b_send();
      @(negedge clk);
      check("wr_rdy_after_b", ifc.d_wr_rdy, 1'b1);
      @(posedge clk); #1;

      // Read to the same line as a pending write is held off until B completes
      wr_req(3'b010, 32'h0000_0100, 4'hF, 128'h9999_8888_7777_6666_5555_4444_5555_AAAA);
      ifc.d_rd_req = 1; ifc.d_rd_type = 3'b010; ifc.d_rd_addr = 32'h0000_0108;
      @(negedge clk);
      check("haz_aw", ifc.d_rd_rdy, 1'b0);
      @(posedge clk); #1;
      aw_accept(8'd0, 3'd2, 32'h0000_0100);
      @(negedge clk);
      check("haz_w", ifc.d_rd_rdy, 1'b0);
      @(posedge clk); #1;
      w_q.push_back({1'b1, 4'hF, 32'h5555_AAAA});
      w_accept(1);
      @(negedge clk);
      check("haz_b", ifc.d_rd_rdy, 1'b0);
      @(posedge clk); #1;
      ifc.bvalid = 1'b1;
      @(negedge clk);
      check("haz_bvalid", ifc.d_rd_rdy, 1'b0);
      @(posedge clk); #1;
      ifc.bvalid = 1'b0;
      @(negedge clk);
      check("haz_clear", ifc.d_rd_rdy, 1'b1);
      @(posedge clk); #1;
      ifc.d_rd_req = 0;
      ar_accept(0, 4'd1, 8'd0, 3'd2, 32'h0000_0108);
      r_send(1, 32'hD000_0108, 1'b1, 1'b1);

      // Byte write: single beat carrying the latched strobe
      wr_req(3'b000, 32'h0000_0203, 4'b0100, 128'hDEADBEEF_01234567_89ABCDEF_00CC0000);
      aw_accept(8'd0, 3'd0, 32'h0000_0203);
      w_q.push_back({1'b1, 4'b0100, 32'h00CC_0000});
      w_accept(1);
      b_send();

      // Reset in the middle of a line read abandons it
      rd_req(1'b0, 3'b100, 32'h0000_0500);
      ar_accept(0, 4'd0, 8'd3, 3'd2, 32'h0000_0500);
      r_send(2, 32'hE000_0000, 1'b0, 1'b0);
      reset = 1'b1;
      ifc.i_rd_req = 1; ifc.i_rd_type = 3'b010; ifc.i_rd_addr = 32'h0000_0600;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_rready", ifc.rready, 1'b0);
      check("rst_mid_ret", {ifc.i_ret_valid, ifc.d_ret_valid}, 2'b00);
      check("rst_mid_arvalid", ifc.arvalid, 1'b0);
      check("rst_mid_i_rdy", ifc.i_rd_rdy, 1'b1);
      check("rst_mid_wr_rdy", ifc.d_wr_rdy, 1'b1);
      @(posedge clk); #1;
      ifc.i_rd_req = 0;
      ar_accept(0, 4'd0, 8'd0, 3'd2, 32'h0000_0600);
      r_send(1, 32'hF000_0600, 1'b0, 1'b1);

      @(posedge clk); #1;
      check("i_q_empty", i_q.size(), 0);
      check("d_q_empty", d_q.size(), 0);
      check("w_q_empty", w_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
